// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: bundles the sequencer's instruction-memory port and ALU port.
//   imem_req/imem_addr   sequencer -> imem   fetch request and address
//   imem_valid/imem_data imem -> sequencer   fetch response
//   alu_inst/alu_exec    sequencer -> ALU    instruction and 1-cycle execute strobe
//   alu_carry/alu_zero   ALU -> sequencer    flags of the last completed ALU op
// master = sequencer side, slave = memory/ALU side.
interface alu_sequencer_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_valid;
    logic [7:0]        imem_data;
    logic [7:0]        alu_inst;
    logic              alu_exec;
    logic              alu_carry;
    logic              alu_zero;

    modport master (
        output imem_req, imem_addr, alu_inst, alu_exec,
        input  imem_valid, imem_data, alu_carry, alu_zero
    );

    modport slave (
        input  imem_req, imem_addr, alu_inst, alu_exec,
        output imem_valid, imem_data, alu_carry, alu_zero
    );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: program sequencer for the 4-bit-opcode ALU datapath.
// Owns the PC, fetches 8-bit instructions {op, data} over a req/valid port, issues
// ALU ops as 1-cycle strobes, resolves jmp/jc/jz, runs nop/hlt locally and faults
// on fetch timeout.
//   clk, rst    clock and synchronous active-high reset
//   run         start pulse, honoured in IDLE only
//   bus         alu_sequencer_if.master (imem and ALU ports)
//   pc          current program counter
//   halted      high in IDLE, HALT and FAULT
//   fault       high in FAULT only
module alu_sequencer #(
    parameter int unsigned ADDR_W        = 8,
    parameter int unsigned RESET_PC      = 0,
    parameter int unsigned FETCH_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    alu_sequencer_if.master     bus,
    output logic [ADDR_W-1:0]   pc,
    output logic                halted,
    output logic                fault
);

    localparam logic [ADDR_W-1:0] ResetPc   = ADDR_W'(RESET_PC);
    localparam bit                TimeoutEn = (FETCH_TIMEOUT != 0);
    // Counter only has to reach FETCH_TIMEOUT-1.
    localparam int unsigned       CntW      = (FETCH_TIMEOUT > 2) ? $clog2(FETCH_TIMEOUT) : 1;
    localparam logic [CntW-1:0]   CntMax    =
        CntW'((FETCH_TIMEOUT == 0) ? 0 : FETCH_TIMEOUT - 1);
    localparam logic [7:0]        InstNop   = 8'h40;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StExec,
        StHalt,
        StFault
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [7:0]        ir_q, ir_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [7:0]        alu_inst_q, alu_inst_d;
    logic              alu_exec_q, alu_exec_d;

    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] pc_jmp;

    // Jump offset is relative to the jump's own address, so use pc_q directly.
    assign pc_inc = pc_q + ADDR_W'(1);
    assign pc_jmp = pc_q + {{(ADDR_W-4){ir_q[3]}}, ir_q[3:0]};

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        cnt_d      = cnt_q;
        alu_inst_d = alu_inst_q;
        alu_exec_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (run) state_d = StFetch;
            end

            StFetch: begin
                // A response on the timeout cycle still wins over the fault.
                if (bus.imem_valid) begin
                    ir_d    = bus.imem_data;
                    cnt_d   = '0;
                    state_d = StExec;
                    // ALU ops are latched here so the strobe is a flop aligned to EXEC.
                    if (bus.imem_data[7:6] == 2'b00) begin
                        alu_inst_d = bus.imem_data;
                        alu_exec_d = 1'b1;
                    end
                end else if (TimeoutEn) begin
                    if (cnt_q == CntMax) begin
                        state_d = StFault;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end

            StExec: begin
                state_d = StFetch;
                case (ir_q[7:4])
                    4'h8:    pc_d = pc_jmp;
                    4'h9:    pc_d = bus.alu_carry ? pc_jmp : pc_inc;
                    4'hA:    pc_d = bus.alu_zero  ? pc_jmp : pc_inc;
                    4'hF:    state_d = StHalt;
                    // ALU ops, nop and undefined opcodes all just advance.
                    default: pc_d = pc_inc;
                endcase
            end

            StHalt, StFault: ;

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            pc_q       <= ResetPc;
            ir_q       <= InstNop;
            cnt_q      <= '0;
            alu_inst_q <= InstNop;
            alu_exec_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            cnt_q      <= cnt_d;
            alu_inst_q <= alu_inst_d;
            alu_exec_q <= alu_exec_d;
        end
    end

    assign bus.imem_req  = (state_q == StFetch);
    assign bus.imem_addr = pc_q;
    assign bus.alu_inst  = alu_inst_q;
    assign bus.alu_exec  = alu_exec_q;

    assign pc     = pc_q;
    assign halted = (state_q == StIdle) || (state_q == StHalt) || (state_q == StFault);
    assign fault  = (state_q == StFault);

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed programs with hand-computed fetch and ALU-strobe
// expectations queued up front; a negedge monitor pops and compares them.
module tb_alu_sequencer;

    localparam int unsigned ADDR_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic run = 1'b0;
    logic mem_en = 1'b1;
    logic carry_v = 1'b0;
    logic zero_v = 1'b0;
    logic [ADDR_W-1:0] pc;
    logic halted;
    logic fault;

    logic [7:0] mem [256];

    int checks = 0;
    int errors = 0;
    bit strict = 1'b1;

    logic [7:0] exp_fetch [$];
    logic [7:0] exp_alu [$];

    always #5 clk = ~clk;

    alu_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    // Zero-wait instruction memory and ALU flag sources.
    assign bus.imem_valid = bus.imem_req & mem_en;
    assign bus.imem_data  = mem[bus.imem_addr];
    assign bus.alu_carry  = carry_v;
    assign bus.alu_zero   = zero_v;

    alu_sequencer #(
        .ADDR_W       (ADDR_W),
        .RESET_PC     (0),
        .FETCH_TIMEOUT(4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .run   (run),
        .bus   (bus),
        .pc    (pc),
        .halted(halted),
        .fault (fault)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %0h expected none", name, act);
    endtask

    // Monitor: compares every accepted fetch and every ALU strobe against the queues.
    always @(negedge clk) begin
        logic [7:0] e;
        if (bus.imem_req && bus.imem_valid) begin
            if (exp_fetch.size() > 0) begin
                e = exp_fetch.pop_front();
                chk("fetch_addr", 32'(bus.imem_addr), 32'(e));
            end else if (strict) begin
                fail("unexpected_fetch", 32'(bus.imem_addr));
            end
        end
        if (bus.alu_exec) begin
            if (exp_alu.size() > 0) begin
                e = exp_alu.pop_front();
                chk("alu_inst", 32'(bus.alu_inst), 32'(e));
            end else begin
                fail("unexpected_alu_exec", 32'(bus.alu_inst));
            end
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'hF0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_run();
        @(negedge clk);
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
    endtask

    // Returns number of negedges waited until halted rises.
    task automatic wait_halt(input int max, output int cycles);
        cycles = 0;
        while (!halted && cycles < max) begin
            @(negedge clk);
            cycles++;
        end
        if (!halted) fail("halt_timeout", 32'(cycles));
    endtask

    task automatic check_halt(input string name, input logic [7:0] exp_pc);
        chk({name, "_halted"}, 32'(halted), 32'd1);
        chk({name, "_pc"}, 32'(pc), 32'(exp_pc));
        chk({name, "_fault"}, 32'(fault), 32'd0);
        chk({name, "_fetch_left"}, 32'(exp_fetch.size()), 32'd0);
        chk({name, "_alu_left"}, 32'(exp_alu.size()), 32'd0);
    endtask

    task automatic run_prog(input string name, input logic [7:0] exp_pc,
                            input logic [7:0] fetches [$], input logic [7:0] alus [$]);
        int cyc;
        exp_fetch = fetches;
        exp_alu   = alus;
        pulse_run();
        wait_halt(200, cyc);
        check_halt(name, exp_pc);
    endtask

    initial begin
        int cyc;
        logic [7:0] prog1 [12];

        clear_mem();
        do_reset();

        // Reset state
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_halted", 32'(halted), 32'd1);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        chk("rst_exec", 32'(bus.alu_exec), 32'd0);
        chk("rst_inst", 32'(bus.alu_inst), 32'h40);

        // 1: straight-line ALU program, 2 cycles per instruction
        prog1 = '{8'h24, 8'h30, 8'h20, 8'h00, 8'h10, 8'h30, 8'h21, 8'h00,
                  8'h30, 8'h28, 8'h00, 8'hF0};
        for (int i = 0; i < 12; i++) mem[i] = prog1[i];
        exp_fetch = '{};
        for (int i = 0; i < 12; i++) exp_fetch.push_back(8'(i));
        exp_alu = '{8'h24, 8'h30, 8'h20, 8'h00, 8'h10, 8'h30, 8'h21, 8'h00,
                    8'h30, 8'h28, 8'h00};
        pulse_run();
        chk("t1_running", 32'(halted), 32'd0);
        wait_halt(200, cyc);
        chk("t1_cycles", 32'(cyc), 32'd24);
        check_halt("t1", 8'd11);
        chk("t1_inst_hold", 32'(bus.alu_inst), 32'h00);

        // HALT ignores run
        pulse_run();
        repeat (3) @(negedge clk);
        chk("t1_run_ignored_pc", 32'(pc), 32'd11);
        chk("t1_run_ignored_req", 32'(bus.imem_req), 32'd0);

        // 2: jmp +4 then halt
        clear_mem();
        mem[0] = 8'h84;
        mem[4] = 8'hF0;
        do_reset();
        run_prog("t2", 8'd4, '{8'd0, 8'd4}, '{});

        // 3: conditional branches
        clear_mem();
        mem[0] = 8'h85;
        mem[5] = 8'h9E;
        mem[3] = 8'hF0;
        mem[6] = 8'hF0;
        mem[8] = 8'hF0;
        carry_v = 1'b1;
        zero_v  = 1'b0;
        do_reset();
        run_prog("t3_jc_taken", 8'd3, '{8'd0, 8'd5, 8'd3}, '{});
        carry_v = 1'b0;
        do_reset();
        run_prog("t3_jc_not", 8'd6, '{8'd0, 8'd5, 8'd6}, '{});
        mem[5] = 8'hA3;
        carry_v = 1'b1;
        do_reset();
        run_prog("t3_jz_not", 8'd6, '{8'd0, 8'd5, 8'd6}, '{});
        zero_v = 1'b1;
        do_reset();
        run_prog("t3_jz_taken", 8'd8, '{8'd0, 8'd5, 8'd8}, '{});
        carry_v = 1'b0;
        zero_v  = 1'b0;

        // 4: PC wrap in both directions; program loops, so stop via rst
        clear_mem();
        mem[0]   = 8'h8E;
        mem[254] = 8'h84;
        mem[2]   = 8'h8D;
        mem[255] = 8'h40;
        do_reset();
        strict = 1'b0;
        exp_fetch = '{8'd0, 8'd254, 8'd2, 8'd255, 8'd0};
        pulse_run();
        cyc = 0;
        while (exp_fetch.size() != 0 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("t4_fetch_left", 32'(exp_fetch.size()), 32'd0);
        chk("t4_running", 32'(halted), 32'd0);
        do_reset();
        strict = 1'b1;

        // 5: fetch timeout after 4 FETCH cycles
        clear_mem();
        mem_en = 1'b0;
        pulse_run();
        chk("t5_req", 32'(bus.imem_req), 32'd1);
        repeat (3) @(negedge clk);
        chk("t5_no_fault_yet", 32'(fault), 32'd0);
        @(negedge clk);
        chk("t5_fault", 32'(fault), 32'd1);
        chk("t5_halted", 32'(halted), 32'd1);
        chk("t5_pc", 32'(pc), 32'd0);
        pulse_run();
        repeat (2) @(negedge clk);
        chk("t5_run_ignored", 32'(fault), 32'd1);
        chk("t5_req_off", 32'(bus.imem_req), 32'd0);
        mem_en = 1'b1;
        do_reset();
        chk("t5_rst_fault", 32'(fault), 32'd0);
        chk("t5_rst_pc", 32'(pc), 32'd0);
        chk("t5_rst_halted", 32'(halted), 32'd1);

        // 6a: rst in FETCH with imem_valid high: no IR load, no strobe
        clear_mem();
        mem[0] = 8'h00;
        strict = 1'b0;
        pulse_run();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_halted", 32'(halted), 32'd1);
        chk("t6_req", 32'(bus.imem_req), 32'd0);
        chk("t6_pc", 32'(pc), 32'd0);
        repeat (3) @(negedge clk);
        chk("t6_stay_idle", 32'(halted), 32'd1);
        strict = 1'b1;

        // 6b: undefined opcodes and nop advance the PC without a strobe
        mem[0] = 8'h50;
        mem[1] = 8'h40;
        mem[2] = 8'h7A;
        mem[3] = 8'hF0;
        do_reset();
        run_prog("t6_undef", 8'd3, '{8'd0, 8'd1, 8'd2, 8'd3}, '{});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
